mem_port_arbiter: RTL

- Shares one single-port synchronous word memory between the CPU instruction-fetch port and the data load/store port.
- Arbitrates per cycle with data priority and a bounded-starvation override for fetch.
- Drives the memory strobe and routes the 1-cycle-latency read data back to the owning requester.
- Sits between cpu_top's i_mem_*/d_mem_* side and a unified memory model or SRAM macro.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates between a fetch port and a data port for one single-port synchronous memory.
// Data requests normally win a conflict. Fetch wins after STARVE_MAX consecutive denials.
// Define MEM_PORT_ARBITER_PERF_EN to add saturating grant and conflict counters.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int          ADDR_W     = 32,
    parameter int          MEM_BYTES  = 4096,
    parameter int          STARVE_MAX = 3,
    parameter logic [31:0] OOR_INSTR  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,

    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_we,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,

    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflicts
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT    = ADDR_W'(MEM_BYTES);
    localparam logic [3:0]        STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0] starve_q;
    logic [3:0] starve_d;

    // Response stage: one slot, filled by every grant, drained the next cycle.
    logic rsp_valid_q;
    logic rsp_valid_d;
    logic rsp_is_data_q;
    logic rsp_is_data_d;
    logic rsp_read_q;
    logic rsp_read_d;
    logic rsp_oor_q;
    logic rsp_oor_d;

    logic i_oor;
    logic d_oor;
    logic fetch_turn;

    assign i_oor = (i_addr >= MEM_LIMIT);
    assign d_oor = (d_addr >= MEM_LIMIT);

    // Grants are held off while reset is asserted so every output reads 0 during reset.
    always_comb begin
        fetch_turn = i_req & (starve_q == STARVE_LIMIT);
        d_gnt      = rst_n & d_req & ~fetch_turn;
        i_gnt      = rst_n & i_req & ~d_gnt;
    end

    always_comb begin
        starve_d = starve_q;
        if (!i_req || i_gnt) begin
            starve_d = 4'd0;
        end else if (d_gnt && (starve_q < STARVE_LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = rst_n ? d_wdata : 32'd0;
        if (d_gnt) begin
            mem_addr = d_addr[ADDR_W-1:2];
            mem_en   = ~d_oor;
            mem_we   = d_oor ? 4'b0000 : d_we;
        end else if (i_gnt) begin
            mem_addr = i_addr[ADDR_W-1:2];
            mem_en   = ~i_oor;
        end
    end

    always_comb begin
        rsp_valid_d   = i_gnt | d_gnt;
        rsp_is_data_d = d_gnt;
        rsp_read_d    = d_gnt ? (d_we == 4'b0000) : 1'b1;
        rsp_oor_d     = d_gnt ? d_oor : (i_gnt & i_oor);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q      <= 4'd0;
            rsp_valid_q   <= 1'b0;
            rsp_is_data_q <= 1'b0;
            rsp_read_q    <= 1'b0;
            rsp_oor_q     <= 1'b0;
        end else begin
            starve_q      <= starve_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_is_data_q <= rsp_is_data_d;
            rsp_read_q    <= rsp_read_d;
            rsp_oor_q     <= rsp_oor_d;
        end
    end

    // Memory read data arrives in the cycle after the strobe and is routed to the owner.
    always_comb begin
        i_rvalid = rsp_valid_q & ~rsp_is_data_q;
        d_rvalid = rsp_valid_q & rsp_is_data_q;
        d_err    = d_rvalid & rsp_oor_q;
        i_rdata  = 32'd0;
        d_rdata  = 32'd0;
        if (i_rvalid) begin
            i_rdata = rsp_oor_q ? OOR_INSTR : mem_rdata;
        end
        if (d_rvalid && rsp_read_q && !rsp_oor_q) begin
            d_rdata = mem_rdata;
        end
    end

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [2:0]       perf_inc;
    logic [2:0][31:0] perf_cnt;

    assign perf_inc = {i_req & d_req & rst_n, d_gnt, i_gnt};

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [31:0] cnt_q;
        logic [31:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (perf_inc[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= 32'd0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign perf_cnt[gi] = cnt_q;
    end

    assign perf_i_grants  = perf_cnt[0];
    assign perf_d_grants  = perf_cnt[1];
    assign perf_conflicts = perf_cnt[2];
`else
    assign perf_i_grants  = 32'd0;
    assign perf_d_grants  = 32'd0;
    assign perf_conflicts = 32'd0;
`endif

endmodule
